// File: rtl/wave_capture_buffer.sv
// Triggered waveform capture: waits for a hysteretic rising crossing (or a timeout), then stores
// 2^DEPTH_LOG2 samples decimated by Period into block RAM; registered read port has 1-cycle latency.
module wave_capture_buffer #(
    parameter int DEPTH_LOG2   = 10,
    parameter int HYST         = 4,
    parameter int TRIG_TIMEOUT = 2000000
) (
    input  logic                  clk_100MHz,
    input  logic                  Rst,
    input  logic [7:0]            ADC_Data,
    input  logic [7:0]            F_Gate,
    input  logic [20:0]           Period,
    input  logic                  Arm,
    input  logic [DEPTH_LOG2-1:0] Rd_Addr,
    output logic [7:0]            Rd_Data,
    output logic                  Busy,
    output logic                  Capture_Done,
    output logic                  Trig_Auto
);

    localparam int                   TO_W      = $clog2(TRIG_TIMEOUT + 1);
    localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(TRIG_TIMEOUT - 1);
    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE,
        ARM_WAIT,
        TRIGGER,
        CAPTURE,
        DONE
    } state_t;

    state_t                state, state_nxt;
    logic [TO_W-1:0]       to_cnt, to_cnt_nxt;
    logic [20:0]           period_l, period_l_nxt;
    logic [20:0]           div_cnt, div_cnt_nxt;
    logic [DEPTH_LOG2-1:0] wr_addr, wr_addr_nxt;
    logic                  trig_auto_nxt;
    logic                  start;
    logic                  we;
    logic [DEPTH_LOG2-1:0] we_addr;
    logic                  low_cond;
    logic                  high_cond;
    logic                  to_hit;

    logic [7:0] mem [2**DEPTH_LOG2];

    // 9-bit compare so F_Gate below HYST can never satisfy the low condition
    assign low_cond  = ({1'b0, ADC_Data} + 9'(HYST)) <= {1'b0, F_Gate};
    assign high_cond = ADC_Data > F_Gate;
    assign to_hit    = (to_cnt == TO_LAST);

    always_comb begin
        state_nxt     = state;
        to_cnt_nxt    = to_cnt;
        period_l_nxt  = period_l;
        div_cnt_nxt   = div_cnt;
        wr_addr_nxt   = wr_addr;
        trig_auto_nxt = Trig_Auto;
        start         = 1'b0;
        we            = 1'b0;
        we_addr       = wr_addr;

        case (state)
            IDLE, DONE: begin
                if (Arm) begin
                    state_nxt     = ARM_WAIT;
                    to_cnt_nxt    = '0;
                    trig_auto_nxt = 1'b0;
                end
            end
            ARM_WAIT: begin
                to_cnt_nxt = to_cnt + 1'b1;
                if (to_hit) begin
                    start         = 1'b1;
                    trig_auto_nxt = 1'b1;
                end else if (low_cond) begin
                    state_nxt = TRIGGER;
                end
            end
            TRIGGER: begin
                to_cnt_nxt = to_cnt + 1'b1;
                // a level crossing wins over a coincident timeout
                if (high_cond) begin
                    start         = 1'b1;
                    trig_auto_nxt = 1'b0;
                end else if (to_hit) begin
                    start         = 1'b1;
                    trig_auto_nxt = 1'b1;
                end
            end
            CAPTURE: begin
                if (div_cnt == period_l - 1'b1) begin
                    we          = 1'b1;
                    div_cnt_nxt = '0;
                    if (wr_addr == LAST_ADDR) begin
                        state_nxt = DONE;
                    end else begin
                        wr_addr_nxt = wr_addr + 1'b1;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // trigger sample goes to address 0 in the same cycle the trigger is seen
        if (start) begin
            we           = 1'b1;
            we_addr      = '0;
            period_l_nxt = (Period == 21'd0) ? 21'd1 : Period;
            div_cnt_nxt  = '0;
            wr_addr_nxt  = DEPTH_LOG2'(1);
            state_nxt    = CAPTURE;
        end
    end

    always_ff @(posedge clk_100MHz or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            to_cnt    <= '0;
            period_l  <= '0;
            div_cnt   <= '0;
            wr_addr   <= '0;
            Trig_Auto <= 1'b0;
        end else begin
            state     <= state_nxt;
            to_cnt    <= to_cnt_nxt;
            period_l  <= period_l_nxt;
            div_cnt   <= div_cnt_nxt;
            wr_addr   <= wr_addr_nxt;
            Trig_Auto <= trig_auto_nxt;
        end
    end

    always_comb begin
        Busy         = (state == ARM_WAIT) || (state == TRIGGER) || (state == CAPTURE);
        Capture_Done = (state == DONE);
    end

    always_ff @(posedge clk_100MHz) begin
        if (we) begin
            mem[we_addr] <= ADC_Data;
        end
    end

    // read-first: a same-address write this cycle is not visible until the next read
    always_ff @(posedge clk_100MHz or negedge Rst) begin
        if (!Rst) begin
            Rd_Data <= '0;
        end else begin
            Rd_Data <= mem[Rd_Addr];
        end
    end

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Directed bench for wave_capture_buffer: status checks inline, read data via a scoreboard queue
// popped by a monitor one cycle after each read request.
module tb_wave_capture_buffer;

    localparam int DL    = 10;
    localparam int TT    = 500;
    localparam int DEPTH = 1 << DL;

    logic          clk_100MHz = 1'b0;
    logic          Rst        = 1'b0;
    logic [7:0]    ADC_Data   = 8'd0;
    logic [7:0]    F_Gate     = 8'd128;
    logic [20:0]   Period     = 21'd1;
    logic          Arm        = 1'b0;
    logic [DL-1:0] Rd_Addr    = '0;
    logic [7:0]    Rd_Data;
    logic          Busy;
    logic          Capture_Done;
    logic          Trig_Auto;

    int   n_chk  = 0;
    int   n_pass = 0;
    bit   ramp_en = 1'b0;
    bit   rd_req  = 1'b0;
    bit   rd_pend = 1'b0;
    logic [7:0] exp_q[$];
    int         addr_q[$];

    wave_capture_buffer #(
        .DEPTH_LOG2  (DL),
        .HYST        (4),
        .TRIG_TIMEOUT(TT)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .Rst         (Rst),
        .ADC_Data    (ADC_Data),
        .F_Gate      (F_Gate),
        .Period      (Period),
        .Arm         (Arm),
        .Rd_Addr     (Rd_Addr),
        .Rd_Data     (Rd_Data),
        .Busy        (Busy),
        .Capture_Done(Capture_Done),
        .Trig_Auto   (Trig_Auto)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    always @(posedge clk_100MHz) rd_pend <= rd_req;

    always @(negedge clk_100MHz) begin : monitor
        logic [7:0] e;
        int         a;
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rd_unexpected: got %0d, expected no read", Rd_Data);
            end else begin
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                chk($sformatf("rd[%0d]", a), Rd_Data, e);
            end
        end
    end

    // Tick n after arm_at observes outputs following edge E(n-1), where E0 samples the Arm.
    task automatic tick(input logic a);
        @(negedge clk_100MHz);
        Arm    = a;
        rd_req = 1'b0;
        if (ramp_en) ADC_Data = ADC_Data + 8'd1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick(1'b0);
    endtask

    task automatic arm_at(input logic [7:0] v);
        @(negedge clk_100MHz);
        Arm      = 1'b1;
        rd_req   = 1'b0;
        ADC_Data = v;
    endtask

    task automatic rd(input int a, input logic [7:0] e);
        tick(1'b0);
        Rd_Addr = a[DL-1:0];
        rd_req  = 1'b1;
        exp_q.push_back(e);
        addr_q.push_back(a);
    endtask

    task automatic drain();
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_100MHz);
        Rst    = 1'b0;
        Arm    = 1'b0;
        rd_req = 1'b0;
        #1;
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Capture_Done, 0);
        chk({tag, "_trig_auto"}, Trig_Auto, 0);
        chk({tag, "_rd_data"}, Rd_Data, 0);
        @(negedge clk_100MHz);
        Rst = 1'b1;
    endtask

    initial begin
        #12;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Capture_Done, 0);
        chk("rst_trig_auto", Trig_Auto, 0);
        chk("rst_rd_data", Rd_Data, 0);
        @(negedge clk_100MHz);
        Rst = 1'b1;
        ticks(3);

        // Period 1 ramp; trigger at E129, Arm pulses in TRIGGER (E5) and CAPTURE (E600) ignored
        ramp_en = 1'b1;
        Period  = 21'd1;
        arm_at(8'd0);
        tick(1'b0);
        chk("p1_busy_after_arm", Busy, 1);
        ticks(3);
        tick(1'b1);
        ticks(594);
        tick(1'b1);
        ticks(552);
        chk("p1_done_early", Capture_Done, 0);
        chk("p1_busy_last", Busy, 1);
        tick(1'b0);
        chk("p1_done", Capture_Done, 1);
        chk("p1_busy_done", Busy, 0);
        chk("p1_trig_auto", Trig_Auto, 0);
        for (int k = 0; k < DEPTH; k++) rd(k, 8'(129 + k));
        drain();

        // Period 3, armed from DONE
        Period = 21'd3;
        arm_at(8'd0);
        tick(1'b0);
        chk("p3_done_drops", Capture_Done, 0);
        chk("p3_busy", Busy, 1);
        ticks(129 + 1023 * 3 - 1);
        chk("p3_done_early", Capture_Done, 0);
        tick(1'b0);
        chk("p3_done", Capture_Done, 1);
        for (int k = 0; k < DEPTH; k++) rd(k, 8'(129 + 3 * k));
        drain();

        // constant 200, Period 0: only the timeout can trigger (edge E_TT)
        ramp_en = 1'b0;
        Period  = 21'd0;
        arm_at(8'd200);
        tick(1'b0);
        chk("to_busy", Busy, 1);
        ticks(TT - 1);
        chk("to_trig_auto_before", Trig_Auto, 0);
        tick(1'b0);
        chk("to_trig_auto", Trig_Auto, 1);
        ticks(1022);
        chk("to_done_early", Capture_Done, 0);
        tick(1'b0);
        chk("to_done", Capture_Done, 1);
        chk("to_trig_auto_done", Trig_Auto, 1);
        for (int k = 0; k < DEPTH; k++) rd(k, 8'd200);
        drain();

        // Period 2, switched to 50 mid-capture; spacing must stay 2
        ramp_en = 1'b1;
        Period  = 21'd2;
        arm_at(8'd0);
        tick(1'b0);
        chk("p2_trig_auto_cleared", Trig_Auto, 0);
        ticks(398);
        Period = 21'd50;
        ticks(1776);
        chk("p2_done_early", Capture_Done, 0);
        tick(1'b0);
        chk("p2_done", Capture_Done, 1);
        for (int k = 0; k < DEPTH; k++) rd(k, 8'(129 + 2 * k));
        drain();

        // next arm picks up Period 50
        arm_at(8'd0);
        ticks(280);
        chk("p50_busy", Busy, 1);
        rd(0, 8'd129);
        rd(1, 8'd179);
        rd(2, 8'd229);
        rd(3, 8'd23);
        drain();
        do_reset("abort");

        // reset when write address is 300 (addr 299 written at E428)
        Period = 21'd1;
        arm_at(8'd0);
        ticks(428);
        chk("mid_busy", Busy, 1);
        do_reset("mid");
        ticks(60);
        chk("post_rst_busy", Busy, 0);
        chk("post_rst_done", Capture_Done, 0);
        rd(299, 8'd172);
        rd(298, 8'd171);
        rd(300, 8'd217);
        rd(0, 8'd129);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
